// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: state encodings, handshake
// levels and small arithmetic helpers used at launch and at sign fix-up.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic        Stop              = 1'b1;
  localparam logic        NoStop            = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic        RstEnable         = 1'b1;

  // Magnitude of an operand; 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude of the most negative word.
  function automatic logic [31:0] abs_word(input logic [31:0] value, input logic is_signed);
    logic [31:0] res;
    if (is_signed && value[31]) begin
      res = (~value) + 32'd1;
    end else begin
      res = value;
    end
    return res;
  endfunction

  function automatic logic [31:0] neg_word_if(input logic [31:0] value, input logic negate);
    logic [31:0] res;
    if (negate) begin
      res = (~value) + 32'd1;
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: trial subtract of the divisor from the
// upper partial remainder, then shift in the quotient bit.
module div_unit_step
  import div_unit_pkg::*;
(
  input  logic [64:0] work_i,
  input  logic [31:0] divisor_i,
  output logic [64:0] work_o
);

  logic [32:0] minuend_s;
  logic [31:0] diff_s;
  logic        borrow_s;

  // The minuend keeps bit 64 so partial remainders above 2^31 are not lost
  // when the divisor itself exceeds 2^31.
  always_comb begin
    minuend_s = work_i[64:32];
    borrow_s  = (minuend_s < {1'b0, divisor_i});
    diff_s    = minuend_s[31:0] - divisor_i;
    if (borrow_s) begin
      work_o = {work_i[63:0], 1'b0};
    end else begin
      work_o = {diff_s, work_i[31:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 divider for the EX stage; raises a stall
// request while a divide is in flight and returns {remainder, quotient}.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  div_state_e  state_r, state_next_s;
  logic [5:0]  cnt_r, cnt_next_s;
  logic [64:0] work_r, work_next_s, step_out_s;
  logic [31:0] divisor_r, divisor_next_s;
  logic        neg_quot_r, neg_quot_next_s;
  logic        neg_rem_r, neg_rem_next_s;
  logic [63:0] result_r, result_next_s;
  logic        ready_r, ready_next_s;
  logic        launch_s;

  div_unit_step u_step (
    .work_i    (work_r),
    .divisor_i (divisor_r),
    .work_o    (step_out_s)
  );

  assign launch_s = (start_i == DivStart) && !annul_i;

  // Next-state and datapath updates; every register holds unless a state says otherwise.
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = cnt_r;
    work_next_s     = work_r;
    divisor_next_s  = divisor_r;
    neg_quot_next_s = neg_quot_r;
    neg_rem_next_s  = neg_rem_r;
    result_next_s   = result_r;
    ready_next_s    = ready_r;
    case (state_r)
      DivFree: begin
        ready_next_s  = DivResultNotReady;
        result_next_s = {ZeroWord, ZeroWord};
        if (launch_s) begin
          if (opdata2_i == ZeroWord) begin
            state_next_s = DivByZero;
          end else begin
            state_next_s    = DivOn;
            cnt_next_s      = 6'd0;
            work_next_s     = {32'd0, abs_word(opdata1_i, signed_div_i), 1'b0};
            divisor_next_s  = abs_word(opdata2_i, signed_div_i);
            neg_quot_next_s = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_next_s  = signed_div_i & opdata1_i[31];
          end
        end else begin
          state_next_s = DivFree;
        end
      end
      DivByZero: begin
        result_next_s = {ZeroWord, ZeroWord};
        if (annul_i) begin
          state_next_s = DivFree;
          ready_next_s = DivResultNotReady;
        end else begin
          state_next_s = DivEnd;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_next_s  = DivFree;
          ready_next_s  = DivResultNotReady;
          result_next_s = {ZeroWord, ZeroWord};
        end else begin
          work_next_s = step_out_s;
          cnt_next_s  = cnt_r + 6'd1;
          // The final step's output feeds the sign fix-up directly.
          if (cnt_r == 6'd31) begin
            state_next_s  = DivEnd;
            result_next_s = {neg_word_if(step_out_s[64:33], neg_rem_r),
                             neg_word_if(step_out_s[31:0], neg_quot_r)};
          end else begin
            state_next_s = DivOn;
          end
        end
      end
      DivEnd: begin
        if (annul_i || (start_i == DivStop)) begin
          state_next_s  = DivFree;
          ready_next_s  = DivResultNotReady;
          result_next_s = {ZeroWord, ZeroWord};
        end else begin
          state_next_s = DivEnd;
          ready_next_s = DivResultReady;
        end
      end
      default: begin
        state_next_s  = DivFree;
        ready_next_s  = DivResultNotReady;
        result_next_s = {ZeroWord, ZeroWord};
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_r    <= DivFree;
      cnt_r      <= 6'd0;
      work_r     <= 65'd0;
      divisor_r  <= ZeroWord;
      neg_quot_r <= 1'b0;
      neg_rem_r  <= 1'b0;
      result_r   <= {ZeroWord, ZeroWord};
      ready_r    <= DivResultNotReady;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      work_r     <= work_next_s;
      divisor_r  <= divisor_next_s;
      neg_quot_r <= neg_quot_next_s;
      neg_rem_r  <= neg_rem_next_s;
      result_r   <= result_next_s;
      ready_r    <= ready_next_s;
    end
  end

  // Stall request is combinational so EX freezes in the same cycle start rises.
  always_comb begin
    if (rst == RstEnable) begin
      stallreq_o = NoStop;
    end else begin
      stallreq_o = start_i & ~ready_r & ~annul_i;
    end
  end

  assign result_o = result_r;
  assign ready_o  = ready_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized divides
// compared against a plain-arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int checks = 0;
  int failures = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  // Reference: truncating division, remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    if (b == 32'd0) begin
      res = 64'd0;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  // Launches a divide at the next rising edge (T) and waits for ready_o.
  // lat is the number of edges after T at which ready_o is first seen (-1 on timeout).
  task automatic launch_wait(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                             input int change_at, output int lat, output int stalls,
                             output logic [63:0] res);
    signed_div_i = sgn;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
    annul_i = 1'b0;
    lat = -1;
    stalls = 0;
    res = 64'd0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == change_at) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = ~sgn;
      end
      if (stallreq_o) stalls++;
      if (ready_o) begin
        lat = k;
        res = result_o;
        break;
      end
    end
  endtask

  // Drops start_i for one edge and checks the outputs clear.
  task automatic drop_start(input string name);
    start_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      failures++;
      $display("FAIL %s_clear: ready=%b result=%h, required ready=0 result=0", name, ready_o, result_o);
    end
  endtask

  task automatic check_div(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int change_at);
    int lat, stalls, exp_lat;
    logic [63:0] res, exp;
    exp = ref_div(sgn, a, b);
    exp_lat = (b == 32'd0) ? 2 : 33;
    launch_wait(sgn, a, b, change_at, lat, stalls, res);
    checks++;
    if (res !== exp || lat != exp_lat || stalls != exp_lat) begin
      failures++;
      $display("FAIL %s: %0s %h/%h result=%h lat=%0d stalls=%0d, required result=%h lat=%0d stalls=%0d",
               name, sgn ? "div" : "divu", a, b, res, lat, stalls, exp, exp_lat, exp_lat);
    end
    checks++;
    if (stallreq_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_stall_low: stallreq=%b with ready, required 0", name, stallreq_o);
    end
    // Result must hold while start stays high.
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || result_o !== exp) begin
      failures++;
      $display("FAIL %s_hold: ready=%b result=%h, required ready=1 result=%h", name, ready_o, result_o, exp);
    end
    drop_start(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b1;
    annul_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    repeat (2) @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0 || stallreq_o !== 1'b0) begin
      failures++;
      $display("FAIL reset: ready=%b result=%h stallreq=%b, required all 0", ready_o, result_o, stallreq_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    check_div("unsigned_100_7", 1'b0, 32'd100, 32'd7, -1);
    check_div("unsigned_max", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, -1);
  endtask

  task automatic test_signed_fixup();
    check_div("signed_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
    check_div("signed_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, -1);
    check_div("signed_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, -1);
  endtask

  task automatic test_div_zero();
    check_div("div_zero", 1'b0, 32'd5, 32'd0, -1);
  endtask

  task automatic test_overflow();
    check_div("overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
  endtask

  task automatic test_annul();
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    annul_i = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
    annul_i = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b0) begin
      failures++;
      $display("FAIL annul_stall: stallreq=%b, required 0", stallreq_o);
    end
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      failures++;
      $display("FAIL annul_clear: ready=%b result=%h, required 0", ready_o, result_o);
    end
    // start and annul together in FREE must not launch.
    repeat (40) @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin
      failures++;
      $display("FAIL annul_blocks_launch: ready=%b, required 0", ready_o);
    end
    annul_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    check_div("after_annul", 1'b1, 32'hFFFF_FC18, 32'd7, -1);
  endtask

  task automatic test_reset_mid();
    signed_div_i = 1'b0;
    opdata1_i = 32'd12345;
    opdata2_i = 32'd11;
    start_i = 1'b1;
    annul_i = 1'b0;
    for (int k = 0; k < 20; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0 || stallreq_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: ready=%b result=%h stallreq=%b, required all 0", ready_o, result_o, stallreq_o);
    end
    start_i = 1'b0;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid_silent: ready=%b result=%h, required 0", ready_o, result_o);
    end
  endtask

  task automatic test_operand_stability();
    check_div("operand_stable", 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 5);
  endtask

  task automatic test_back_to_back();
    check_div("b2b_first", 1'b0, 32'd99, 32'd10, -1);
    check_div("b2b_second", 1'b1, 32'hFFFF_FF9D, 32'd10, -1);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic sgn;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      case ($urandom_range(3, 0))
        0: b = $urandom_range(15, 0);
        1: b = $urandom & 32'h0000_FFFF;
        2: b = -($urandom_range(300, 1));
        default: b = $urandom;
      endcase
      sgn = $urandom_range(1, 0);
      check_div("random", sgn, a, b, -1);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed_fixup();
    test_div_zero();
    test_overflow();
    test_annul();
    test_reset_mid();
    test_operand_stability();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
